alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Multi-cycle unsigned multiply/divide sequencer (MULTU/DIVU) for the EXE stage.
- Has no multiplier or divider of its own. It borrows the shared EXE-stage ALU through an operand/command port and runs 32 iterations: shift-add for multiply, restoring shift-subtract for divide.
- Results land in HI/LO registers.
- busy stalls the pipeline and switches the EXE ALU operand mux to this block.

Parameters:
- WORD_LEN, 32, datapath width; iteration count equals WORD_LEN.
- EXE_CMD_LEN, 4, width of the ALU command; EXE_ADD and EXE_SUB encodings come from the shared defines file.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = MULTU, 1 = DIVU.
- src_a  input  WORD_LEN  multiplicand / dividend.
- src_b  input  WORD_LEN  multiplier / divisor.
- busy  output  1  high while the operation is in progress (MUL, DIV and DONE states).
- alu_own  output  1  equals busy; selects this block onto the ALU inputs.
- alu_val1  output  WORD_LEN  ALU operand 1.
- alu_val2  output  WORD_LEN  ALU operand 2.
- alu_cmd  output  EXE_CMD_LEN  ALU command.
- alu_out  input  WORD_LEN  combinational ALU result for this cycle's operands.
- done  output  1  one-cycle pulse; hi/lo valid from this cycle.
- div_by_zero  output  1  sticky flag for the last operation; cleared on the next accepted start.
- hi  output  WORD_LEN  MULTU: product[63:32]; DIVU: remainder.
- lo  output  WORD_LEN  MULTU: product[31:0]; DIVU: quotient.

Behaviour:
- Reset: state IDLE; busy, alu_own, done, div_by_zero = 0; hi = lo = 0; count = 0; alu_val1 = alu_val2 = 0; alu_cmd = EXE_ADD.
- Reset during an operation aborts it, returns to IDLE and clears hi/lo. No done pulse is produced.
- States: IDLE, MUL, DIV, DONE.
- IDLE with start = 1 (accept edge):
  - Latch src_a into M_a and src_b into M_b.
  - Clear div_by_zero and count = 0.
  - op = 0: acc = 0, q = src_b, go to MUL.
  - op = 1 with src_b != 0: acc = 0, q = src_a, go to DIV.
  - op = 1 with src_b == 0: set div_by_zero, hi = src_a, lo = all-ones, go to DONE directly.
- MUL, one iteration per cycle:
  - Drive alu_val1 = acc, alu_val2 = M_a, alu_cmd = EXE_ADD.
  - If q[0]: sum = alu_out, carry = (alu_out < acc), unsigned compare.
  - Else: sum = acc, carry = 0.
  - Update {acc, q} <= {carry, sum, q} >> 1; count++.
- DIV, one iteration per cycle:
  - Form s = {acc[WORD_LEN-2:0], q[WORD_LEN-1]} and msb = acc[WORD_LEN-1].
  - Drive alu_val1 = s, alu_val2 = M_b, alu_cmd = EXE_SUB.
  - If msb or (s >= M_b): acc <= alu_out, q <= {q[WORD_LEN-2:0], 1}.
  - Else: acc <= s, q <= {q[WORD_LEN-2:0], 0}.
  - count++.
- Termination: after the iteration with count == WORD_LEN-1, write hi <= acc' and lo <= q' (post-update values) and go to DONE.
- DONE: done = 1 for exactly one cycle; busy is still 1; next state IDLE.
- Latency: accept edge at cycle 0; done visible in cycle WORD_LEN+1 (33); busy deasserts in cycle WORD_LEN+2. Divide-by-zero case: done in cycle 1.
- start while not IDLE is ignored; no queueing. start asserted in the DONE cycle is also ignored, and the requester re-asserts it.
- hi and lo change only on completion or reset; they hold between operations.
- Outside MUL/DIV the ALU ports hold their reset values; alu_own = 0 in IDLE.
- All arithmetic is unsigned and modulo 2^WORD_LEN, except that the carry/msb logic above provides the 65th/33rd bit.

Test Plan:
- MULTU 7 × 6 -> done at cycle 33; hi = 0, lo = 42; busy high for cycles 1–33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001. Exercises the carry path.
- DIVU 100 / 7 -> lo = 14, hi = 2. DIVU 0xFFFFFFFF / 1 -> lo = 0xFFFFFFFF, hi = 0. DIVU 0x80000000 / 0xFFFFFFFF -> lo = 0, hi = 0x80000000.
- DIVU 5 / 0 -> done in cycle 1, div_by_zero = 1, hi = 5, lo = 0xFFFFFFFF. A following MULTU 2 × 3 clears div_by_zero and gives lo = 6.
- start pulsed at cycles 5 and 33 during an operation -> ignored; exactly one done pulse; result unchanged.
- rst at cycle 10 of MULTU 7 × 6 -> IDLE next cycle, busy = 0, hi = lo = 0, no done. A new start then completes normally.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
// Multi-cycle unsigned MULTU/DIVU sequencer for the EXE stage. It owns no
// arithmetic unit: each iteration borrows the shared EXE ALU through the
// alu_val1/alu_val2/alu_cmd port and consumes alu_out in the same cycle.
// Multiply is shift-add, divide is restoring shift-subtract, WORD_LEN
// iterations each. Results land in hi/lo.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, op           request (sampled in IDLE only), 0 = MULTU, 1 = DIVU
//   src_a, src_b        multiplicand/dividend, multiplier/divisor
//   busy, alu_own       operation in progress / ALU operand mux select
//   alu_val1, alu_val2  ALU operands driven while iterating
//   alu_cmd             ALU command (EXE_ADD or EXE_SUB)
//   alu_out             combinational ALU result for this cycle's operands
//   done                one-cycle pulse, hi/lo valid from this cycle
//   div_by_zero         sticky flag for the last operation
//   hi, lo              MULTU: product[63:32]/[31:0]; DIVU: remainder/quotient
//
// state | meaning
// IDLE  | waiting for start; ALU ports parked at ADD with zero operands
// MUL   | one shift-add iteration per cycle
// DIV   | one restoring shift-subtract iteration per cycle
// DONE  | done pulse; busy still high, back to IDLE next cycle
module alu_muldiv_seq #(
  parameter int WORD_LEN    = 32,
  parameter int EXE_CMD_LEN = 4,
  parameter logic [EXE_CMD_LEN-1:0] EXE_ADD = EXE_CMD_LEN'(0),
  parameter logic [EXE_CMD_LEN-1:0] EXE_SUB = EXE_CMD_LEN'(2)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op,
  input  logic [WORD_LEN-1:0]    src_a,
  input  logic [WORD_LEN-1:0]    src_b,
  output logic                   busy,
  output logic                   alu_own,
  output logic [WORD_LEN-1:0]    alu_val1,
  output logic [WORD_LEN-1:0]    alu_val2,
  output logic [EXE_CMD_LEN-1:0] alu_cmd,
  input  logic [WORD_LEN-1:0]    alu_out,
  output logic                   done,
  output logic                   div_by_zero,
  output logic [WORD_LEN-1:0]    hi,
  output logic [WORD_LEN-1:0]    lo
);

  localparam int CNT_W = $clog2(WORD_LEN);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WORD_LEN - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state;
  logic [WORD_LEN-1:0] m_a;
  logic [WORD_LEN-1:0] m_b;
  logic [WORD_LEN-1:0] acc;
  logic [WORD_LEN-1:0] q;
  logic [CNT_W-1:0]    count;

  logic [WORD_LEN-1:0] mul_sum;
  logic                mul_carry;
  logic [WORD_LEN-1:0] mul_acc_nx;
  logic [WORD_LEN-1:0] mul_q_nx;
  logic [WORD_LEN-1:0] div_s;
  logic                div_ge;
  logic [WORD_LEN-1:0] div_acc_nx;
  logic [WORD_LEN-1:0] div_q_nx;

  assign alu_own = busy;

  // The ALU is only 32 bits wide; the lost carry of acc + M_a is recovered
  // by the unsigned wrap test, and the dropped top bit of the shifted
  // remainder (acc msb) forces a subtract in the divide step.
  always_comb begin
    mul_sum    = q[0] ? alu_out : acc;
    mul_carry  = q[0] && (alu_out < acc);
    mul_acc_nx = {mul_carry, mul_sum[WORD_LEN-1:1]};
    mul_q_nx   = {mul_sum[0], q[WORD_LEN-1:1]};

    div_s      = {acc[WORD_LEN-2:0], q[WORD_LEN-1]};
    div_ge     = acc[WORD_LEN-1] || (div_s >= m_b);
    div_acc_nx = div_ge ? alu_out : div_s;
    div_q_nx   = {q[WORD_LEN-2:0], div_ge};
  end

  always_comb begin
    alu_val1 = '0;
    alu_val2 = '0;
    alu_cmd  = EXE_ADD;
    case (state)
      MUL: begin
        alu_val1 = acc;
        alu_val2 = m_a;
        alu_cmd  = EXE_ADD;
      end
      DIV: begin
        alu_val1 = div_s;
        alu_val2 = m_b;
        alu_cmd  = EXE_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      count       <= '0;
      m_a         <= '0;
      m_b         <= '0;
      acc         <= '0;
      q           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_a         <= src_a;
            m_b         <= src_b;
            div_by_zero <= 1'b0;
            count       <= '0;
            acc         <= '0;
            busy        <= 1'b1;
            if (!op) begin
              q     <= src_b;
              state <= MUL;
            end else if (src_b != '0) begin
              q     <= src_a;
              state <= DIV;
            end else begin
              // Divide by zero skips the iterations entirely.
              div_by_zero <= 1'b1;
              hi          <= src_a;
              lo          <= '1;
              done        <= 1'b1;
              state       <= DONE;
            end
          end
        end
        MUL: begin
          acc   <= mul_acc_nx;
          q     <= mul_q_nx;
          count <= count + CNT_W'(1);
          if (count == LAST_ITER) begin
            hi    <= mul_acc_nx;
            lo    <= mul_q_nx;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DIV: begin
          acc   <= div_acc_nx;
          q     <= div_q_nx;
          count <= count + CNT_W'(1);
          if (count == LAST_ITER) begin
            hi    <= div_acc_nx;
            lo    <= div_q_nx;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq. The bench supplies the shared EXE
// ALU, predicts every result with native arithmetic into a scoreboard queue
// and compares when done fires.
module tb_alu_muldiv_seq;
  localparam int W  = 32;
  localparam int CW = 4;
  localparam logic [CW-1:0] ADD = 4'd0;
  localparam logic [CW-1:0] SUB = 4'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          op = 1'b0;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic          busy, alu_own, done, div_by_zero;
  logic [W-1:0]  alu_val1, alu_val2, alu_out, hi, lo;
  logic [CW-1:0] alu_cmd;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Shared EXE ALU stand-in; an unknown command yields a poison value.
  always_comb begin
    if (alu_cmd == ADD)      alu_out = alu_val1 + alu_val2;
    else if (alu_cmd == SUB) alu_out = alu_val1 - alu_val2;
    else                     alu_out = 32'hDEADBEEF;
  end

  alu_muldiv_seq #(.WORD_LEN(W), .EXE_CMD_LEN(CW), .EXE_ADD(ADD), .EXE_SUB(SUB)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .alu_own(alu_own), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_cmd(alu_cmd), .alu_out(alu_out), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  task automatic push_exp(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    if (!o) begin
      p = {32'b0, a} * {32'b0, b};
      e.hi = p[2*W-1:W]; e.lo = p[W-1:0]; e.dbz = 1'b0;
    end else if (b == 0) begin
      e.hi = a; e.lo = '1; e.dbz = 1'b1;
    end else begin
      e.hi = a % b; e.lo = a / b; e.dbz = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Issues one request and waits (bounded) for done. lat is the cycle of
  // done counted from the accept edge, -1 if it never came.
  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_lo, output logic [CW-1:0] cmd1,
                        output logic [W-1:0] v1_1, output logic [W-1:0] v2_1);
    push_exp(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; busy_lo = 0; cmd1 = '0; v1_1 = '0; v2_1 = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) begin cmd1 = alu_cmd; v1_1 = alu_val1; v2_1 = alu_val2; end
      if (!busy || !alu_own) busy_lo++;
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, alu_own, done, div_by_zero} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b, want 0000", {busy, alu_own, done, div_by_zero});
    end
    checks++;
    if (hi !== '0 || lo !== '0) begin
      errors++; $display("FAIL reset_hilo: got hi=%h lo=%h, want 0 0", hi, lo);
    end
    checks++;
    if (alu_val1 !== '0 || alu_val2 !== '0 || alu_cmd !== ADD) begin
      errors++; $display("FAIL reset_alu: got v1=%h v2=%h cmd=%h, want 0 0 %h", alu_val1, alu_val2, alu_cmd, ADD);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, blo;
    logic [CW-1:0] c1;
    logic [W-1:0] v1, v2;
    exp_t e;
    run_op(1'b0, a, b, lat, blo, c1, v1, v2);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL mul_latency %h*%h: got %0d, want 33", a, b, lat); end
    checks++;
    if (blo !== 0) begin errors++; $display("FAIL mul_busy: %0d cycles low in 1..done, want 0", blo); end
    checks++;
    if (c1 !== ADD || v1 !== '0 || v2 !== a) begin
      errors++; $display("FAIL mul_alu_drive: got cmd=%h v1=%h v2=%h, want %h 0 %h", c1, v1, v2, ADD, a);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL mul_scoreboard: got empty queue, want one entry");
    end else begin
      e = sb.pop_front();
      if (hi !== e.hi || lo !== e.lo || div_by_zero !== e.dbz) begin
        errors++; $display("FAIL mul_result %h*%h: got hi=%h lo=%h dbz=%b, want hi=%h lo=%h dbz=%b",
                           a, b, hi, lo, div_by_zero, e.hi, e.lo, e.dbz);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mul_after_done: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_divu(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, blo;
    logic [CW-1:0] c1;
    logic [W-1:0] v1, v2, s1;
    exp_t e;
    s1 = a >> (W - 1);
    run_op(1'b1, a, b, lat, blo, c1, v1, v2);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL div_latency %h/%h: got %0d, want 33", a, b, lat); end
    checks++;
    if (blo !== 0) begin errors++; $display("FAIL div_busy: %0d cycles low in 1..done, want 0", blo); end
    checks++;
    if (c1 !== SUB || v1 !== s1 || v2 !== b) begin
      errors++; $display("FAIL div_alu_drive: got cmd=%h v1=%h v2=%h, want %h %h %h", c1, v1, v2, SUB, s1, b);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL div_scoreboard: got empty queue, want one entry");
    end else begin
      e = sb.pop_front();
      if (hi !== e.hi || lo !== e.lo || div_by_zero !== e.dbz) begin
        errors++; $display("FAIL div_result %h/%h: got hi=%h lo=%h dbz=%b, want hi=%h lo=%h dbz=%b",
                           a, b, hi, lo, div_by_zero, e.hi, e.lo, e.dbz);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL div_after_done: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_div_by_zero(input logic [W-1:0] a);
    int lat, blo;
    logic [CW-1:0] c1;
    logic [W-1:0] v1, v2;
    exp_t e;
    run_op(1'b1, a, '0, lat, blo, c1, v1, v2);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL dbz_latency: got %0d, want 1", lat); end
    checks++;
    if (c1 !== ADD || v1 !== '0 || v2 !== '0) begin
      errors++; $display("FAIL dbz_alu_parked: got cmd=%h v1=%h v2=%h, want %h 0 0", c1, v1, v2, ADD);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL dbz_scoreboard: got empty queue, want one entry");
    end else begin
      e = sb.pop_front();
      if (hi !== e.hi || lo !== e.lo || div_by_zero !== e.dbz) begin
        errors++; $display("FAIL dbz_result: got hi=%h lo=%h dbz=%b, want hi=%h lo=%h dbz=%b",
                           hi, lo, div_by_zero, e.hi, e.lo, e.dbz);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || div_by_zero !== 1'b1) begin
      errors++; $display("FAIL dbz_sticky: got busy=%b dbz=%b, want 0 1", busy, div_by_zero);
    end
  endtask

  task automatic test_ignore_start;
    int dones = 0, dcyc = -1, busy_cnt = 0;
    exp_t e;
    push_exp(1'b0, 7, 6);
    @(negedge clk);
    start = 1'b1; op = 1'b0; src_a = 7; src_b = 6;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin dones++; dcyc = n; end
      if (busy) busy_cnt++;
      // Pulses sampled at the end of cycles 5 (MUL) and 33 (DONE).
      start = (n == 5 || n == 33); op = 1'b1; src_a = 99; src_b = 3;
    end
    start = 1'b0;
    checks++;
    if (dones !== 1 || dcyc !== 33) begin
      errors++; $display("FAIL ignore_done_count: got %0d pulses last at %0d, want 1 at 33", dones, dcyc);
    end
    checks++;
    if (busy_cnt !== 33) begin
      errors++; $display("FAIL ignore_busy_cycles: got %0d, want 33", busy_cnt);
    end
    checks++;
    e = sb.pop_front();
    if (hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL ignore_result: got hi=%h lo=%h, want hi=%h lo=%h", hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_reset_abort;
    int dones = 0;
    @(negedge clk);
    start = 1'b1; op = 1'b0; src_a = 7; src_b = 6;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 10; n++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || alu_own !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_flags: got busy=%b own=%b done=%b, want 0 0 0", busy, alu_own, done);
    end
    checks++;
    if (hi !== '0 || lo !== '0) begin
      errors++; $display("FAIL abort_hilo: got hi=%h lo=%h, want 0 0", hi, lo);
    end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses, want 0", dones); end
    test_multu(32'd5, 32'd9);
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      test_multu(a, b);
      b = b >> $urandom_range(0, 31);
      if (b == 0) b = 1;
      test_divu(a, b);
    end
  endtask

  initial begin
    test_reset;
    test_multu(32'd7, 32'd6);
    test_multu(32'hFFFFFFFF, 32'hFFFFFFFF);
    test_divu(32'd100, 32'd7);
    test_divu(32'hFFFFFFFF, 32'd1);
    test_divu(32'h80000000, 32'hFFFFFFFF);
    test_div_by_zero(32'd5);
    test_multu(32'd2, 32'd3);
    test_ignore_start;
    test_reset_abort;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "watchdog");
  end

endmodule
